// File: rtl/adder_pkg.sv
// Purpose: shared FSM state type and sizing helpers for the chunked serial adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width; a single-chunk build still needs a 1-bit index.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder_cell.sv
// Purpose: combinational CHUNK-bit ripple adder built from full-adder cells.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake at this level.
module chunk_adder_cell
    import adder_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/chunked_serial_adder.sv
// Purpose: WIDTH-bit a+b+cin summed CHUNK bits per cycle, carry registered between chunks (ADD_SUB_EN adds a sub port).
// Latency: out_valid rises NCHUNK cycles after the accept edge; one op per NCHUNK+2 cycles.
// Backpressure: result held in DONE while out_ready=0; in_ready stays low until the result is taken.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               carry_q, cout_q;
    logic [IDX_W-1:0]   idx_q;

    logic [WIDTH-1:0]   b_load;
    logic               carry_load;
    int                 base;
    logic [CHUNK-1:0]   a_chunk, b_chunk, chunk_s;
    logic               chunk_co;

    // Operand conditioning at accept: subtraction is a + ~b + 1, cin ignored.
    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef ADD_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    assign base    = int'(idx_q) * CHUNK;
    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];

    chunk_adder_cell #(.CHUNK(CHUNK)) u_cell (
        .x  (a_chunk),
        .y  (b_chunk),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, decoded straight from the state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one chunk per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        idx_q   <= '0;
                    end
                end
                BUSY: begin
                    sum_q[base +: CHUNK] <= chunk_s;
                    carry_q              <= chunk_co;
                    idx_q                <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) cout_q <= chunk_co;
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Purpose: directed and swept checks of chunked_serial_adder at CHUNK=2 (main) and CHUNK=1/4/8.
// Latency: expects out_valid exactly WIDTH/CHUNK cycles after the accept edge.
// Backpressure: exercises long out_ready=0 holds and back-to-back accepts.
`timescale 1ns/1ps
module tb_chunked_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid_v  [4];
    logic       in_ready_v  [4];
    logic       cin_v       [4];
    logic       out_valid_v [4];
    logic       out_ready_v [4];
    logic       cout_v      [4];
    logic [7:0] a_v         [4];
    logic [7:0] b_v         [4];
    logic [7:0] sum_v       [4];
`ifdef ADD_SUB_EN
    logic       sub_v       [4];
`endif

    int total = 0;
    int bad   = 0;

    // Instance 0: CHUNK=2, instance 1: CHUNK=1, instance 2: CHUNK=4, instance 3: CHUNK=8.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int CH = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 8;
        chunked_serial_adder #(.WIDTH(8), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[gi]),
            .in_ready  (in_ready_v[gi]),
            .a         (a_v[gi]),
            .b         (b_v[gi]),
            .cin       (cin_v[gi]),
`ifdef ADD_SUB_EN
            .sub       (sub_v[gi]),
`endif
            .out_valid (out_valid_v[gi]),
            .out_ready (out_ready_v[gi]),
            .sum       (sum_v[gi]),
            .cout      (cout_v[gi])
        );
    end

    function automatic int nch(input int k);
        case (k)
            0:       return 4;
            1:       return 8;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    // Present operands and hold in_valid until an edge where in_ready was high.
    // Called and returns at #1 after a rising edge; operands are scrambled after accept.
    task automatic do_accept(input int k, input logic [7:0] av, input logic [7:0] bv,
                             input logic ci, input logic sb);
        bit was_rdy;
        in_valid_v[k] = 1'b1;
        a_v[k]        = av;
        b_v[k]        = bv;
        cin_v[k]      = ci;
`ifdef ADD_SUB_EN
        sub_v[k]      = sb;
`else
        if (sb) $display("note: sub request ignored in add-only build");
`endif
        for (int i = 0; i < 50; i++) begin
            was_rdy = in_ready_v[k];
            @(posedge clk);
            #1;
            if (was_rdy) break;
        end
        in_valid_v[k] = 1'b0;
        a_v[k]        = 8'($urandom);
        b_v[k]        = 8'($urandom);
        cin_v[k]      = 1'($urandom);
    endtask

    // Count cycles from the accept edge until out_valid; -1 if it never rises.
    task automatic wait_done(input int k, output int lat);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_v[k]) begin
                lat = i;
                break;
            end
        end
    endtask

    // Take the result with a single-cycle out_ready pulse.
    task automatic take_result(input int k);
        out_ready_v[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (in_ready_v[0] !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready_v[0]); end
        total++; if (out_valid_v[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid_v[0]); end
        total++; if (sum_v[0] !== 8'h00)      begin bad++; $display("FAIL reset_sum: got %h want 00", sum_v[0]); end
        total++; if (cout_v[0] !== 1'b0)      begin bad++; $display("FAIL reset_cout: got %b want 0", cout_v[0]); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        do_accept(0, 8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(0, lat);
        total++; if (lat !== 4)          begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
        total++; if (sum_v[0] !== 8'h10) begin bad++; $display("FAIL basic_sum: got %h want 10", sum_v[0]); end
        total++; if (cout_v[0] !== 1'b0) begin bad++; $display("FAIL basic_cout: got %b want 0", cout_v[0]); end
        take_result(0);
    endtask

    task automatic test_carry();
        logic [7:0] av [3] = '{8'hFF, 8'h7F, 8'hFF};
        logic [7:0] bv [3] = '{8'h01, 8'h00, 8'hFF};
        logic       cv [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] es [3] = '{8'h00, 8'h80, 8'hFF};
        logic       ec [3] = '{1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_accept(0, av[i], bv[i], cv[i], 1'b0);
            wait_done(0, lat);
            total++; if (lat !== 4)          begin bad++; $display("FAIL carry_latency[%0d]: got %0d want 4", i, lat); end
            total++; if (sum_v[0] !== es[i]) begin bad++; $display("FAIL carry_sum[%0d]: got %h want %h", i, sum_v[0], es[i]); end
            total++; if (cout_v[0] !== ec[i]) begin bad++; $display("FAIL carry_cout[%0d]: got %b want %b", i, cout_v[0], ec[i]); end
            take_result(0);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_accept(0, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency: got %0d want 4", lat); end
        // Offer a competing operand pair while stalled; it must be ignored.
        in_valid_v[0] = 1'b1;
        a_v[0]        = 8'hAA;
        b_v[0]        = 8'h11;
        for (int i = 0; i < 10; i++) begin
            total++; if (sum_v[0] !== 8'h46)      begin bad++; $display("FAIL bp_sum[%0d]: got %h want 46", i, sum_v[0]); end
            total++; if (out_valid_v[0] !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid_v[0]); end
            total++; if (in_ready_v[0] !== 1'b0)  begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready_v[0]); end
            @(posedge clk);
            #1;
        end
        total++; if (cout_v[0] !== 1'b0) begin bad++; $display("FAIL bp_cout: got %b want 0", cout_v[0]); end
        in_valid_v[0] = 1'b0;
        take_result(0);
        total++; if (out_valid_v[0] !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid_v[0]); end
        total++; if (in_ready_v[0] !== 1'b1)  begin bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready_v[0]); end
    endtask

    task automatic test_midreset();
        int lat;
        do_accept(0, 8'hC3, 8'h5A, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        // Now in the second BUSY cycle.
        rst_n = 1'b0;
        #1;
        total++; if (in_ready_v[0] !== 1'b1)  begin bad++; $display("FAIL mrst_in_ready: got %b want 1", in_ready_v[0]); end
        total++; if (out_valid_v[0] !== 1'b0) begin bad++; $display("FAIL mrst_out_valid: got %b want 0", out_valid_v[0]); end
        total++; if (sum_v[0] !== 8'h00)      begin bad++; $display("FAIL mrst_sum: got %h want 00", sum_v[0]); end
        total++; if (cout_v[0] !== 1'b0)      begin bad++; $display("FAIL mrst_cout: got %b want 0", cout_v[0]); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_accept(0, 8'h03, 8'h04, 1'b0, 1'b0);
        wait_done(0, lat);
        total++; if (lat !== 4)          begin bad++; $display("FAIL mrst_next_latency: got %0d want 4", lat); end
        total++; if (sum_v[0] !== 8'h07) begin bad++; $display("FAIL mrst_next_sum: got %h want 07", sum_v[0]); end
        total++; if (cout_v[0] !== 1'b0) begin bad++; $display("FAIL mrst_next_cout: got %b want 0", cout_v[0]); end
        take_result(0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [3] = '{8'h05, 8'h80, 8'h3C};
        logic [7:0] bv [3] = '{8'h06, 8'h80, 8'h0F};
        logic [7:0] es [3] = '{8'h0B, 8'h00, 8'h4B};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        out_ready_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_accept(0, av[i], bv[i], 1'b0, 1'b0);
            wait_done(0, lat);
            total++; if (lat !== 4)           begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 4", i, lat); end
            total++; if (sum_v[0] !== es[i])  begin bad++; $display("FAIL b2b_sum[%0d]: got %h want %h", i, sum_v[0], es[i]); end
            total++; if (cout_v[0] !== ec[i]) begin bad++; $display("FAIL b2b_cout[%0d]: got %b want %b", i, cout_v[0], ec[i]); end
        end
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        total++; if (in_ready_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b want 1", in_ready_v[0]); end
    endtask

`ifdef ADD_SUB_EN
    task automatic test_sub();
        int lat;
        // cin=1 must be ignored when subtracting.
        do_accept(0, 8'h05, 8'h07, 1'b1, 1'b1);
        wait_done(0, lat);
        total++; if (sum_v[0] !== 8'hFE) begin bad++; $display("FAIL sub_borrow_sum: got %h want FE", sum_v[0]); end
        total++; if (cout_v[0] !== 1'b0) begin bad++; $display("FAIL sub_borrow_cout: got %b want 0", cout_v[0]); end
        take_result(0);
        do_accept(0, 8'h07, 8'h05, 1'b0, 1'b1);
        wait_done(0, lat);
        total++; if (sum_v[0] !== 8'h02) begin bad++; $display("FAIL sub_noborrow_sum: got %h want 02", sum_v[0]); end
        total++; if (cout_v[0] !== 1'b1) begin bad++; $display("FAIL sub_noborrow_cout: got %b want 1", cout_v[0]); end
        take_result(0);
        sub_v[0] = 1'b0;
    endtask
`endif

    task automatic test_sweep();
        logic [7:0] av, bv;
        logic       ci;
        logic [8:0] exp_full;
        int         lat, stall;
        for (int k = 1; k < 4; k++) begin
            for (int n = 0; n < 15; n++) begin
                av       = 8'($urandom);
                bv       = 8'($urandom);
                ci       = 1'($urandom);
                exp_full = {1'b0, av} + {1'b0, bv} + {8'h00, ci};
                do_accept(k, av, bv, ci, 1'b0);
                wait_done(k, lat);
                total++; if (lat !== nch(k)) begin bad++; $display("FAIL sweep_latency k=%0d n=%0d: got %0d want %0d", k, n, lat, nch(k)); end
                stall = $urandom_range(0, 3);
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
                total++; if (sum_v[k] !== exp_full[7:0]) begin bad++; $display("FAIL sweep_sum k=%0d %h+%h+%b: got %h want %h", k, av, bv, ci, sum_v[k], exp_full[7:0]); end
                total++; if (cout_v[k] !== exp_full[8])  begin bad++; $display("FAIL sweep_cout k=%0d %h+%h+%b: got %b want %b", k, av, bv, ci, cout_v[k], exp_full[8]); end
                take_result(k);
                total++; if (out_valid_v[k] !== 1'b0) begin bad++; $display("FAIL sweep_release k=%0d: got %b want 0", k, out_valid_v[k]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
            a_v[k]         = 8'h00;
            b_v[k]         = 8'h00;
            cin_v[k]       = 1'b0;
`ifdef ADD_SUB_EN
            sub_v[k]       = 1'b0;
`endif
        end
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_midreset();
        test_back_to_back();
`ifdef ADD_SUB_EN
        test_sub();
`endif
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
